// File: rtl/bus_access_sched_pkg.sv
// Shared types for the Bus-A access scheduler: speed classes, owners,
// request payload and the raw address-to-speed map.
package bus_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {
    MEM_FAST  = 2'd0,
    MEM_SLOW  = 2'd1,
    MEM_XSLOW = 2'd2,
    MEM_VAR   = 2'd3
  } mem_speed_type;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_HDMA = 2'd3
  } bus_owner_type;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
  } bus_req_t;

  // Raw speed of an address; MEM_VAR is left for the caller to resolve.
  function automatic mem_speed_type addr_speed(input logic [ADDR_W-1:0] addr);
    logic [7:0]  bank;
    logic [15:0] off;
    bank = addr[23:16];
    off  = addr[15:0];
    if (bank[6])              addr_speed = bank[7] ? MEM_VAR : MEM_SLOW;
    else if (off < 16'h2000)  addr_speed = MEM_SLOW;
    else if (off < 16'h4000)  addr_speed = MEM_FAST;
    else if (off < 16'h4200)  addr_speed = MEM_XSLOW;
    else if (off < 16'h6000)  addr_speed = MEM_FAST;
    else if (off < 16'h8000)  addr_speed = MEM_SLOW;
    else                      addr_speed = bank[7] ? MEM_VAR : MEM_SLOW;
  endfunction

endpackage

// File: rtl/bus_access_sched_if.sv
// Requester-side handshake and granted Bus-A outputs of the scheduler.
interface bus_access_sched_if;
  import bus_pkg::*;

  logic              memsel;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_we;
  logic              hdma_req;
  logic [ADDR_W-1:0] hdma_addr;
  logic              hdma_we;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic              bus_active;
  logic [1:0]        bus_speed;
  logic [1:0]        bus_owner;
  logic              cpu_ack;
  logic              dma_ack;
  logic              hdma_ack;

  modport master (
    output memsel, cpu_req, cpu_addr, cpu_we, dma_req, dma_addr, dma_we,
           hdma_req, hdma_addr, hdma_we,
    input  bus_addr, bus_we, bus_active, bus_speed, bus_owner,
           cpu_ack, dma_ack, hdma_ack
  );

  modport slave (
    input  memsel, cpu_req, cpu_addr, cpu_we, dma_req, dma_addr, dma_we,
           hdma_req, hdma_addr, hdma_we,
    output bus_addr, bus_we, bus_active, bus_speed, bus_owner,
           cpu_ack, dma_ack, hdma_ack
  );
endinterface

// File: rtl/bus_access_sched_mem_speed_decode.sv
// Combinational CPU address decode: resolved speed class and access length.
module mem_speed_decode
  import bus_pkg::*;
#(
  parameter int unsigned FAST_LEN  = 6,
  parameter int unsigned SLOW_LEN  = 8,
  parameter int unsigned XSLOW_LEN = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              memsel,
  output mem_speed_type     speed,
  output logic [LEN_W-1:0]  len
);

  mem_speed_type raw;

  always_comb begin
    raw   = addr_speed(addr);
    speed = raw;
    if (raw == MEM_VAR) speed = memsel ? MEM_FAST : MEM_SLOW;
    case (speed)
      MEM_FAST:  len = LEN_W'(FAST_LEN);
      MEM_XSLOW: len = LEN_W'(XSLOW_LEN);
      default:   len = LEN_W'(SLOW_LEN);
    endcase
  end

endmodule

// File: rtl/bus_access_sched.sv
// Bus-A access scheduler: fixed-priority grant (HDMA > DMA > CPU), holds the
// bus for the access length and pulses the owner's ack in the last cycle.
module bus_access_sched
  import bus_pkg::*;
#(
  parameter int unsigned FAST_LEN  = 6,
  parameter int unsigned SLOW_LEN  = 8,
  parameter int unsigned XSLOW_LEN = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_access_sched_if.slave bif
);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic              bus_active;
  mem_speed_type     bus_speed;
  bus_owner_type     bus_owner;
  logic              cpu_ack;
  logic              dma_ack;
  logic              hdma_ack;

  mem_speed_type     cpu_speed;
  logic [LEN_W-1:0]  cpu_len;
  bus_owner_type     grant_own;
  bus_req_t          grant_req;
  mem_speed_type     grant_speed;
  logic [LEN_W-1:0]  grant_len;

  mem_speed_decode #(
    .FAST_LEN  (FAST_LEN),
    .SLOW_LEN  (SLOW_LEN),
    .XSLOW_LEN (XSLOW_LEN)
  ) u_decode (
    .addr   (bif.cpu_addr),
    .memsel (bif.memsel),
    .speed  (cpu_speed),
    .len    (cpu_len)
  );

  // Fixed-priority grant candidate; DMA channels always run at slow timing.
  always_comb begin
    grant_own   = OWN_NONE;
    grant_req   = '{addr: '0, we: 1'b0};
    grant_speed = MEM_SLOW;
    grant_len   = LEN_W'(SLOW_LEN);
    if (bif.hdma_req) begin
      grant_own = OWN_HDMA;
      grant_req = '{addr: bif.hdma_addr, we: bif.hdma_we};
    end else if (bif.dma_req) begin
      grant_own = OWN_DMA;
      grant_req = '{addr: bif.dma_addr, we: bif.dma_we};
    end else if (bif.cpu_req) begin
      grant_own   = OWN_CPU;
      grant_req   = '{addr: bif.cpu_addr, we: bif.cpu_we};
      grant_speed = cpu_speed;
      grant_len   = cpu_len;
    end
  end

  // Ack is registered one cycle ahead so it lands in the cnt==0 cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bus_addr   <= '0;
      bus_we     <= 1'b0;
      bus_active <= 1'b0;
      bus_speed  <= MEM_FAST;
      bus_owner  <= OWN_NONE;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      hdma_ack   <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
      hdma_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_own != OWN_NONE) begin
            state      <= ST_ACCESS;
            cnt        <= grant_len - LEN_W'(1);
            bus_addr   <= grant_req.addr;
            bus_we     <= grant_req.we;
            bus_active <= 1'b1;
            bus_speed  <= grant_speed;
            bus_owner  <= grant_own;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state      <= ST_IDLE;
            bus_active <= 1'b0;
            bus_owner  <= OWN_NONE;
          end else begin
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              case (bus_owner)
                OWN_CPU:  cpu_ack  <= 1'b1;
                OWN_DMA:  dma_ack  <= 1'b1;
                OWN_HDMA: hdma_ack <= 1'b1;
                default:  ;
              endcase
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bif.bus_addr   = bus_addr;
  assign bif.bus_we     = bus_we;
  assign bif.bus_active = bus_active;
  assign bif.bus_speed  = bus_speed;
  assign bif.bus_owner  = bus_owner;
  assign bif.cpu_ack    = cpu_ack;
  assign bif.dma_ack    = dma_ack;
  assign bif.hdma_ack   = hdma_ack;

endmodule

// File: doc/bus_access_sched.md
Name: bus_access_sched

Overview:
- Bus-A access scheduler. Arbitrates the 24-bit Bus-A between three requesters: CPU, general-purpose DMA and HDMA.
- Classifies each granted access into a mem_speed_type and holds the bus for the matching number of master-clock cycles.
- Pulses a per-requester acknowledge when the access completes.
- Sits between the CPU core / DMA engine and the Bus-A address decode; one clk cycle equals one master clock.

Parameters:
- FAST_LEN, 6, master cycles for a MEM_FAST access
- SLOW_LEN, 8, master cycles for a MEM_SLOW access (also used for every DMA/HDMA access)
- XSLOW_LEN, 12, master cycles for a MEM_XSLOW access

Ports:
- clk  in  1  master clock
- rst_n  in  1  synchronous active-low reset
- memsel  in  1  MEMSEL bit 0; 1 = MEM_VAR resolves to fast
- cpu_req  in  1  CPU access request, level; held until cpu_ack
- cpu_addr  in  24  CPU address
- cpu_we  in  1  CPU write
- dma_req  in  1  GP-DMA request, level
- dma_addr  in  24  DMA A-bus address
- dma_we  in  1  DMA write
- hdma_req  in  1  HDMA request, level
- hdma_addr  in  24  HDMA A-bus address
- hdma_we  in  1  HDMA write
- bus_addr  out  24  granted address
- bus_we  out  1  granted write strobe
- bus_active  out  1  access in progress
- bus_speed  out  2  mem_speed_type of the current access
- bus_owner  out  2  bus_owner_type of the current owner
- cpu_ack  out  1  one-cycle completion pulse
- dma_ack  out  1  one-cycle completion pulse
- hdma_ack  out  1  one-cycle completion pulse

Behaviour:
- Reset values: state IDLE; bus_addr 0; bus_we 0; bus_active 0; bus_speed MEM_FAST; bus_owner OWN_NONE; all acks 0.
- States: IDLE and ACCESS, plus a 4-bit down-counter cnt.
- IDLE, when any request is asserted:
  - Grant by fixed priority HDMA > DMA > CPU.
  - Register the owner's addr/we into bus_addr/bus_we.
  - Resolve the length: DMA/HDMA always use SLOW_LEN; CPU uses the decoded speed length.
  - Set cnt = length-1 and move to ACCESS on the next edge.
- memsel is sampled only at grant. A change mid-access has no effect.
- ACCESS:
  - bus_active=1 for exactly `length` cycles; cnt decrements each cycle.
  - In the cycle where cnt==0, the owner's ack is 1. The next edge returns to IDLE, bus_active=0 and bus_owner=OWN_NONE.
- One IDLE cycle always separates accesses: request-to-ack latency is length cycles, and bus occupancy is length+1.
- No preemption. An HDMA request arriving mid-access waits for the current ack.
- A requester deasserting mid-access does not abort it; the access completes and is acked.
- A requester must drop its request, or present a new address, in the cycle after its ack. A request still high in IDLE is a new access.
- Speed decode (bank B = addr[23:16], offset O = addr[15:0]):
  - B in 00-3F or 80-BF:
    - O 0000-1FFF: SLOW
    - O 2000-3FFF: FAST
    - O 4000-41FF: XSLOW
    - O 4200-5FFF: FAST
    - O 6000-7FFF: SLOW
    - O 8000-FFFF: SLOW for B 00-3F, VAR for B 80-BF
  - B 40-7F: SLOW.
  - B C0-FF: VAR.
  - bus_speed reports the resolved speed, never MEM_VAR: VAR maps to FAST if memsel else SLOW.
  - DMA/HDMA report MEM_SLOW.
- Reset asserted mid-access: next edge forces reset values, no ack is issued, and the aborted access is lost.

Decomposition:
- Add to bus_pkg:
  - enum bus_owner_type {OWN_NONE, OWN_CPU, OWN_DMA, OWN_HDMA}
  - function addr_speed(addr) returning mem_speed_type, including MEM_VAR
- Sub-module mem_speed_decode: combinational. Inputs addr and memsel; outputs the resolved mem_speed_type and a 4-bit length.

Test Plan:
- CPU read 7E:0000 at cycle 0 -> ACCESS cycles 1-8, bus_speed=MEM_SLOW, cpu_ack high in cycle 8, bus_active=0 in cycle 9.
- CPU read 00:4016 -> bus_speed=MEM_XSLOW, 12 active cycles, one cpu_ack.
- CPU read 80:8000 with memsel=1 -> FAST, 6 cycles. Repeat with memsel=0 -> SLOW, 8 cycles. Toggle memsel at active cycle 2 -> length unchanged.
- cpu_req, dma_req and hdma_req all raised in the same cycle -> grants in order HDMA, DMA, CPU. Each takes 8 cycles plus one IDLE gap, with acks in cycles 8, 17 and 26 (CPU at 00:0000).
- DMA write to 00:2118 -> MEM_SLOW, 8 cycles despite the FAST region; bus_we=1 throughout.
- rst_n low at active cycle 3 -> next cycle all outputs at reset values, no ack pulse; access restarts after release if the request is held.
